// File: rtl/sample_stream_player.sv
// ============================================================================
// Module   : sample_stream_player
// Brief    : RAM-backed sample source streaming a programmable block over
//            valid/ready, with one-shot/loop modes and output pacing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_stream_player #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int DIV_W     = 8,
    parameter     INIT_FILE = "signal.txt"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   length,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] sample_idx,
    output logic              busy,
    output logic              done
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_PACE  = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   len_q,   len_d;
    logic              loop_q,  loop_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [DIV_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic              done_q,  done_d;
    logic [DATA_W-1:0] m_data_q;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic              is_last;

    logic unused_init_w;
    assign unused_init_w = ^INIT_FILE;

    assign is_last = ({1'b0, addr_q} == (len_q - 1'b1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        loop_d   = loop_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = addr_q;
        nxt_addr = is_last ? '0 : addr_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = (length > LEN_MAX) ? LEN_MAX : length;
                        loop_d  = loop_en;
                        div_d   = rate_div;
                        addr_d  = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_en   = 1'b1;
                    idx_d   = addr_q;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // stop wins over a simultaneous transfer: the run ends silently
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (m_ready) begin
                    if (is_last && !loop_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = nxt_addr;
                        idx_d   = nxt_addr;
                        rd_en   = 1'b1;
                        rd_addr = nxt_addr;
                        if (div_q != '0) begin
                            state_d = ST_PACE;
                            cnt_d   = div_q;
                        end
                    end
                end
            end
            ST_PACE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= DIV_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // RAM and its output register carry no reset so they map onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            m_data_q <= mem[rd_addr];
        end
    end

    assign m_valid    = (state_q == ST_SEND);
    assign m_data     = m_data_q;
    assign sample_idx = idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_stream_player.sv
// ============================================================================
// Module   : tb_sample_stream_player
// Brief    : Scoreboard bench for sample_stream_player with a reference RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_stream_player;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [10:0] length = '0;
   logic [7:0]  rate_div = '0;
   logic        wr_en = 1'b0;
   logic [9:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [15:0] m_data;
   logic [9:0]  sample_idx;
   logic        busy;
   logic        done;

   sample_stream_player dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .loop_en    (loop_en),
      .length     (length),
      .rate_div   (rate_div),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .sample_idx (sample_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic [9:0]  i;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] ref_mem [DEPTH];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   xfers = 0;
   int   done_cnt = 0;
   int   done_cyc = -100;
   int   last_xfer_cyc = -1;
   int   pace_div = 0;
   bit   pace_exact = 1'b0;
   bit   stalled = 1'b0;
   logic busy_at_done = 1'b0;
   logic [15:0] held_d;
   logic [9:0]  held_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: inputs settle before this edge, so valid&ready here is a transfer
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled && m_valid) begin
            chk("hold_data", m_data, held_d);
            chk("hold_idx", sample_idx, held_i);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_xfer", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("xfer_data", m_data, e.d);
               chk("xfer_idx", sample_idx, e.i);
            end
            if (last_xfer_cyc >= 0) begin
               if (pace_exact) chk("pace_gap", cyc - last_xfer_cyc, pace_div + 1);
               else            chk("pace_min_gap", 32'(cyc - last_xfer_cyc >= pace_div + 1), 1);
            end
            last_xfer_cyc = cyc;
            xfers++;
         end
         stalled = m_valid && !m_ready;
         held_d  = m_data;
         held_i  = sample_idx;
         if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
         end
      end
   end

   task automatic wr_word(input int addr, input logic [15:0] data);
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_addr = 10'(addr);
      wr_data = data;
      ref_mem[addr] = data;
   endtask

   task automatic wr_close();
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // rmode: 0 = always ready, 1 = random ready, 2 = one 5-cycle stall at sample 3
   task automatic run(input int len, input bit lp, input int div, input int rmode,
                      input int stop_after, input bit wr_busy, input bit use_rst);
      int n, d0, x0, budget, k, stall_left;
      bit stall_done;
      exp_t e;
      n = (len > DEPTH) ? DEPTH : len;
      if (n > 0) begin
         if (!lp) begin
            for (int i = 0; i < n; i++) begin
               e.d = ref_mem[i]; e.i = 10'(i); exp_q.push_back(e);
            end
         end else begin
            for (int i = 0; i < stop_after; i++) begin
               e.d = ref_mem[i % n]; e.i = 10'(i % n); exp_q.push_back(e);
            end
         end
      end
      last_xfer_cyc = -1;
      pace_div      = div;
      pace_exact    = (rmode == 0);
      d0 = done_cnt; x0 = xfers; stall_left = 0; stall_done = 1'b0;

      @(posedge clk); #1;
      start    = 1'b1;
      length   = 11'(len);
      loop_en  = lp;
      rate_div = 8'(div);
      m_ready  = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;

      if (n == 0) begin
         @(negedge clk);
         chk("len0_done", done, 1);
         chk("len0_busy", busy, 0);
         @(negedge clk);
         chk("len0_done_once", done, 0);
         chk("len0_valid", m_valid, 0);
         chk("len0_done_cnt", done_cnt - d0, 1);
         return;
      end

      @(negedge clk);
      chk("fetch_valid", m_valid, 0);
      chk("fetch_busy", busy, 1);
      @(negedge clk);
      chk("first_valid", m_valid, 1);

      budget = 8 * (n + stop_after + 10) * (div + 2) + 100;
      k = 0;
      while (1) begin
         @(posedge clk); #1;
         k++;
         if (!lp && done_cnt != d0) break;
         if (lp && (xfers - x0) >= stop_after) break;
         if (k > budget) begin
            chk("timeout", 0, 1);
            break;
         end
         case (rmode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
               if (!stall_done && (xfers - x0) == 3) begin
                  stall_left = 5; stall_done = 1'b1;
               end
               m_ready = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
         endcase
         // writes and restarts while busy must be ignored; stay clear of the run's end
         if (wr_busy && (xfers - x0 + 3) <= n) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = ~ref_mem[0];
            start = 1'b1; length = 11'd1;
         end else begin
            wr_en = 1'b0; start = 1'b0;
         end
      end
      m_ready = 1'b0; wr_en = 1'b0; start = 1'b0;

      if (lp) begin
         if (use_rst) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst_valid", m_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_idx", sample_idx, 0);
         end else begin
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            @(negedge clk);
            chk("stop_valid", m_valid, 0);
            chk("stop_busy", busy, 0);
            chk("stop_done", done, 0);
            chk("loop_queue_empty", exp_q.size(), 0);
         end
         chk("loop_no_done", done_cnt - d0, 0);
      end else begin
         chk("done_after_last", done_cyc - last_xfer_cyc, 1);
         chk("busy_at_done", busy_at_done, 0);
         chk("queue_empty", exp_q.size(), 0);
         @(negedge clk);
         @(negedge clk);
         chk("single_done", done_cnt - d0, 1);
      end
      exp_q.delete();
   endtask

   initial begin
      int len, lp, div, sa;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_valid", m_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_idx", sample_idx, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) wr_word(i, 16'($urandom));
      for (int i = 0; i < 8; i++)     wr_word(i, 16'h0100 + 16'(i));
      wr_close();

      run(8, 0, 0, 0, 0, 0, 0);     // basic one-shot
      run(8, 0, 0, 2, 0, 0, 0);     // backpressure stall on 0103
      run(4, 0, 3, 0, 0, 0, 0);     // paced
      run(4, 1, 0, 0, 10, 0, 0);    // loop, then stop
      run(8, 1, 0, 0, 3, 0, 1);     // reset mid-SEND
      run(8, 0, 0, 0, 0, 0, 0);     // RAM retained across reset
      run(0, 0, 0, 0, 0, 0, 0);     // zero length
      run(8, 0, 1, 0, 0, 1, 0);     // writes/start while busy ignored
      run(8, 0, 0, 0, 0, 0, 0);     // mem[0] unchanged
      run(1, 1, 0, 1, 5, 0, 0);     // single-sample loop
      run(1024, 0, 0, 0, 0, 0, 0);  // full depth
      run(1500, 0, 0, 0, 0, 0, 0);  // clamped to depth

      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < 4; w++) wr_word(int'($urandom_range(0, 40)), 16'($urandom));
         wr_close();
         len = int'($urandom_range(1, 40));
         lp  = int'($urandom_range(0, 1));
         div = int'($urandom_range(0, 3));
         sa  = int'($urandom_range(1, 2 * len + 2));
         run(len, lp[0], div, 1, sa, 0, 0);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
